// File: rtl/instr_decode_pkg.sv
// Shared KGP_RISC definitions: widths, opcodes, ALU codes and the decode table.
package kgp_pkg;

  localparam int DATA_W = 32;
  localparam int PC_W   = 8;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_LW    = 6'h02;
  localparam logic [5:0] OP_SW    = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h05;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Which instruction field names the destination register.
  typedef enum logic [1:0] {
    DEST_NONE = 2'd0,
    DEST_RD   = 2'd1,
    DEST_RT   = 2'd2
  } dest_sel_e;

  typedef struct packed {
    ctrl_t     ctrl;
    dest_sel_e dest;
    logic      rs_used;
    logic      rt_used;
  } dec_t;

  // Opcode -> control bits, destination selection and source usage.
  function automatic dec_t decode(input logic [5:0] opcode, input logic [3:0] funct);
    dec_t d;
    d = '0;
    case (opcode)
      OP_RTYPE: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_op    = funct;
        d.dest           = DEST_RD;
        d.rs_used        = 1'b1;
        d.rt_used        = 1'b1;
      end
      OP_ADDI: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.alu_op    = ALU_ADD;
        d.dest           = DEST_RT;
        d.rs_used        = 1'b1;
      end
      OP_LW: begin
        d.ctrl.reg_write = 1'b1;
        d.ctrl.mem_read  = 1'b1;
        d.ctrl.alu_op    = ALU_ADD;
        d.dest           = DEST_RT;
        d.rs_used        = 1'b1;
      end
      OP_SW: begin
        d.ctrl.mem_write = 1'b1;
        d.ctrl.alu_op    = ALU_ADD;
        d.rs_used        = 1'b1;
        d.rt_used        = 1'b1;
      end
      OP_BEQ: begin
        d.ctrl.branch = 1'b1;
        d.ctrl.alu_op = ALU_SUB;
        d.rs_used     = 1'b1;
        d.rt_used     = 1'b1;
      end
      OP_J: begin
        d.ctrl.jump = 1'b1;
      end
      default: begin
        d.ctrl.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/instr_decode_if.sv
// ID/EX pipeline register bus: decode drives it (master), execute consumes it (slave).
interface instr_decode_if #(
  parameter int DATA_W = kgp_pkg::DATA_W,
  parameter int PC_W   = kgp_pkg::PC_W,
  parameter int AW     = kgp_pkg::REG_AW
) ();

  logic              ex_valid;
  logic [PC_W-1:0]   ex_npc;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [AW-1:0]     ex_rs;
  logic [AW-1:0]     ex_rt;
  logic [AW-1:0]     ex_rd;
  logic [3:0]        ex_alu_op;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_branch;
  logic              ex_jump;
  logic              ex_illegal;

  modport master (
    output ex_valid, ex_npc, ex_rs_data, ex_rt_data, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_alu_op,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal
  );

  modport slave (
    input ex_valid, ex_npc, ex_rs_data, ex_rt_data, ex_imm,
          ex_rs, ex_rt, ex_rd, ex_alu_op,
          ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal
  );

endinterface

// File: rtl/instr_decode_rf.sv
// 32x32 register file: two async read ports with write-through bypass,
// one synchronous write port, synchronous active-low clear. r0 is hardwired to 0.
module reg_file_32x32 #(
  parameter int DATA_W = kgp_pkg::DATA_W,
  parameter int NREG   = kgp_pkg::NREG,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [NREG];
  logic              wr_en;

  assign wr_en = we && (waddr != '0);

  // Storage: clear everything on reset, otherwise commit the write-back.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports: r0 reads zero; a same-cycle write to the read address is forwarded.
  always_comb begin
    rdata_a = mem[raddr_a];
    rdata_b = mem[raddr_b];
    if (wr_en && (waddr == raddr_a)) rdata_a = wdata;
    if (wr_en && (waddr == raddr_b)) rdata_b = wdata;
    if (raddr_a == '0) rdata_a = '0;
    if (raddr_b == '0) rdata_b = '0;
  end

endmodule

// File: rtl/instr_decode.sv
// KGP_RISC decode stage: field extraction, control decode, register read,
// load-use hazard detection and the ID/EX pipeline register.
module instr_decode import kgp_pkg::*; #(
  parameter int DATA_W = kgp_pkg::DATA_W,
  parameter int PC_W   = kgp_pkg::PC_W,
  parameter int NREG   = kgp_pkg::NREG,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [31:0]       instr,
  input  logic [PC_W-1:0]   npc,
  input  logic              if_valid,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_if,
  instr_decode_if.master    ex
);

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   npc;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic [AW-1:0]     rd;
    ctrl_t             ctrl;
  } idex_t;

  logic [5:0]        opcode;
  logic [AW-1:0]     rs;
  logic [AW-1:0]     rt;
  logic [AW-1:0]     rd_r;
  logic [3:0]        funct;
  logic [15:0]       imm;
  logic [6:0]        unused_instr;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [AW-1:0]     dest;
  logic              hz;
  dec_t              dec;
  idex_t             idex_d;
  idex_t             idex_q;

  assign opcode       = instr[31:26];
  assign rs           = instr[25:21];
  assign rt           = instr[20:16];
  assign rd_r         = instr[15:11];
  assign funct        = instr[3:0];
  assign imm          = instr[15:0];
  assign unused_instr = instr[10:4];

  assign dec = decode(opcode, funct);

  reg_file_32x32 #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_rf (
    .clk1    (clk1),
    .rst     (rst),
    .raddr_a (rs),
    .rdata_a (rs_data),
    .raddr_b (rt),
    .rdata_b (rt_data),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data)
  );

  // Destination register number; instructions that write nothing carry r0.
  always_comb begin
    dest = '0;
    case (dec.dest)
      DEST_RD: dest = rd_r;
      DEST_RT: dest = rt;
      default: dest = '0;
    endcase
  end

  // A load in EX whose target is read by the instruction in ID cannot be forwarded in time.
  assign hz = ex.ex_valid & idex_q.ctrl.mem_read & (idex_q.rd != '0) &
              ((dec.rs_used & (rs == idex_q.rd)) | (dec.rt_used & (rt == idex_q.rd))) &
              if_valid;

  // A flush kills the instruction in ID, so there is nothing left to hold.
  assign stall_if = hz & ~flush;

  // Next ID/EX contents: bubble on flush or hazard, else load with controls gated by if_valid.
  always_comb begin
    idex_d = '0;
    if (!(flush || hz)) begin
      idex_d.valid   = if_valid;
      idex_d.npc     = npc;
      idex_d.rs_data = rs_data;
      idex_d.rt_data = rt_data;
      idex_d.imm     = {{(DATA_W-16){imm[15]}}, imm};
      idex_d.rs      = rs;
      idex_d.rt      = rt;
      idex_d.rd      = dest;
      idex_d.ctrl    = if_valid ? dec.ctrl : CTRL_NOP;
    end
  end

  // ID/EX pipeline register with synchronous clear.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      idex_q <= '0;
    end else begin
      idex_q <= idex_d;
    end
  end

  assign ex.ex_valid     = idex_q.valid;
  assign ex.ex_npc       = idex_q.npc;
  assign ex.ex_rs_data   = idex_q.rs_data;
  assign ex.ex_rt_data   = idex_q.rt_data;
  assign ex.ex_imm       = idex_q.imm;
  assign ex.ex_rs        = idex_q.rs;
  assign ex.ex_rt        = idex_q.rt;
  assign ex.ex_rd        = idex_q.rd;
  assign ex.ex_alu_op    = idex_q.ctrl.alu_op;
  assign ex.ex_reg_write = idex_q.ctrl.reg_write;
  assign ex.ex_mem_read  = idex_q.ctrl.mem_read;
  assign ex.ex_mem_write = idex_q.ctrl.mem_write;
  assign ex.ex_branch    = idex_q.ctrl.branch;
  assign ex.ex_jump      = idex_q.ctrl.jump;
  assign ex.ex_illegal   = idex_q.ctrl.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed scenarios plus randomized traffic
// compared against a behavioural model of the decode stage.
module tb_instr_decode;
  import kgp_pkg::*;

  logic        clk1 = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] instr = 32'h0;
  logic [7:0]  npc = 8'h0;
  logic        if_valid = 1'b0;
  logic        flush = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'h0;
  logic        stall_if;

  instr_decode_if ex_bus ();

  instr_decode dut (
    .clk1     (clk1),
    .rst      (rst),
    .instr    (instr),
    .npc      (npc),
    .if_valid (if_valid),
    .flush    (flush),
    .wb_we    (wb_we),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .stall_if (stall_if),
    .ex       (ex_bus)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed {
    logic        valid;
    logic [7:0]  npc;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        j;
    logic        ill;
  } idex_t;

  typedef struct packed {
    logic       rw, mr, mw, br, j, ill;
    logic [3:0] alu;
    logic [4:0] dest;
    logic       rsu, rtu;
  } mdec_t;

  logic [31:0] m_regs [32];
  idex_t       m_ex;
  logic        last_stall = 1'b0;
  int          checks = 0;
  int          failures = 0;

  // Reference decode, straight from the instruction table.
  function automatic mdec_t m_dec(input logic [31:0] i);
    mdec_t d;
    d = '0;
    case (i[31:26])
      6'h00: begin d.rw = 1; d.alu = i[3:0]; d.dest = i[15:11]; d.rsu = 1; d.rtu = 1; end
      6'h01: begin d.rw = 1; d.alu = 4'h0; d.dest = i[20:16]; d.rsu = 1; end
      6'h02: begin d.rw = 1; d.mr = 1; d.alu = 4'h0; d.dest = i[20:16]; d.rsu = 1; end
      6'h03: begin d.mw = 1; d.alu = 4'h0; d.rsu = 1; d.rtu = 1; end
      6'h04: begin d.br = 1; d.alu = 4'h1; d.rsu = 1; d.rtu = 1; end
      6'h05: begin d.j = 1; end
      default: begin d.ill = 1; end
    endcase
    return d;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic m_hazard();
    mdec_t d;
    d = m_dec(instr);
    return m_ex.valid && m_ex.mr && (m_ex.rd != 5'd0) && if_valid &&
           ((d.rsu && instr[25:21] == m_ex.rd) || (d.rtu && instr[20:16] == m_ex.rd));
  endfunction

  function automatic idex_t m_next();
    idex_t n;
    mdec_t d;
    n = '0;
    if (!rst || flush || m_hazard()) return n;
    d = m_dec(instr);
    n.valid   = if_valid;
    n.npc     = npc;
    n.rs_data = m_read(instr[25:21]);
    n.rt_data = m_read(instr[20:16]);
    n.imm     = {{16{instr[15]}}, instr[15:0]};
    n.rs      = instr[25:21];
    n.rt      = instr[20:16];
    n.rd      = d.dest;
    if (if_valid) begin
      n.alu = d.alu; n.rw = d.rw; n.mr = d.mr; n.mw = d.mw;
      n.br = d.br; n.j = d.j; n.ill = d.ill;
    end
    return n;
  endfunction

  function automatic idex_t observe();
    idex_t o;
    o.valid = ex_bus.ex_valid;      o.npc = ex_bus.ex_npc;
    o.rs_data = ex_bus.ex_rs_data;  o.rt_data = ex_bus.ex_rt_data;
    o.imm = ex_bus.ex_imm;          o.rs = ex_bus.ex_rs;
    o.rt = ex_bus.ex_rt;            o.rd = ex_bus.ex_rd;
    o.alu = ex_bus.ex_alu_op;       o.rw = ex_bus.ex_reg_write;
    o.mr = ex_bus.ex_mem_read;      o.mw = ex_bus.ex_mem_write;
    o.br = ex_bus.ex_branch;        o.j = ex_bus.ex_jump;
    o.ill = ex_bus.ex_illegal;
    return o;
  endfunction

  // One clock with inputs already applied: check stall_if, advance, check ID/EX.
  task automatic step(input string name);
    idex_t exp_n;
    logic  exp_stall;
    #1;
    exp_stall = m_hazard() & ~flush;
    last_stall = exp_stall;
    checks++;
    if (stall_if !== exp_stall) begin
      failures++;
      $display("FAIL %s stall_if actual=%b expected=%b", name, stall_if, exp_stall);
    end
    exp_n = m_next();
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    end else if (wb_we && wb_addr != 5'd0) begin
      m_regs[wb_addr] = wb_data;
    end
    @(posedge clk1);
    #1;
    m_ex = exp_n;
    checks++;
    if (observe() !== exp_n) begin
      failures++;
      $display("FAIL %s idex actual=%h expected=%h", name, observe(), exp_n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; instr = 32'h0822_0005; if_valid = 1'b1; npc = 8'h10;
    wb_we = 1'b1; wb_addr = 5'd1; wb_data = 32'h1111_1111;
    repeat (2) @(posedge clk1);
    #1;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_ex = '0;
    checks++;
    if (observe() !== idex_t'(0)) begin
      failures++;
      $display("FAIL reset_idex actual=%h expected=0", observe());
    end
    rst = 1'b1; wb_we = 1'b0;
    for (int i = 1; i < 32; i++) begin
      instr = {6'h00, 5'(i), 5'(i), 5'd0, 11'd0};
      step("reset_rf_read");
      checks++;
      if (ex_bus.ex_rs_data !== 32'h0 || ex_bus.ex_rt_data !== 32'h0) begin
        failures++;
        $display("FAIL reset_rf r%0d actual=%h/%h expected=0", i, ex_bus.ex_rs_data, ex_bus.ex_rt_data);
      end
    end
  endtask

  task automatic test_addi();
    instr = 32'h0401_FFFD; npc = 8'h04; if_valid = 1'b1;
    step("addi");
    checks++;
    if ({ex_bus.ex_valid, ex_bus.ex_imm, ex_bus.ex_rd, ex_bus.ex_reg_write, ex_bus.ex_alu_op, ex_bus.ex_npc}
        !== {1'b1, 32'hFFFF_FFFD, 5'd1, 1'b1, ALU_ADD, 8'h04}) begin
      failures++;
      $display("FAIL addi_fields actual=%b/%h/%0d/%b/%h/%h expected=1/fffffffd/1/1/0/04",
               ex_bus.ex_valid, ex_bus.ex_imm, ex_bus.ex_rd, ex_bus.ex_reg_write, ex_bus.ex_alu_op, ex_bus.ex_npc);
    end
  endtask

  task automatic test_bypass();
    instr = {6'h00, 5'd2, 5'd0, 5'd5, 11'd0};
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEAD_BEEF;
    step("bypass");
    checks++;
    if (ex_bus.ex_rs_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL bypass_rs actual=%h expected=deadbeef", ex_bus.ex_rs_data);
    end
    wb_we = 1'b0;
    step("bypass_stored");
    checks++;
    if (ex_bus.ex_rs_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL stored_r2 actual=%h expected=deadbeef", ex_bus.ex_rs_data);
    end
    instr = {6'h00, 5'd0, 5'd0, 5'd5, 11'd0};
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h1234_5678;
    step("wb_r0");
    wb_we = 1'b0;
    step("read_r0");
    checks++;
    if (ex_bus.ex_rs_data !== 32'h0) begin
      failures++;
      $display("FAIL r0_read actual=%h expected=0", ex_bus.ex_rs_data);
    end
  endtask

  task automatic test_load_use();
    if_valid = 1'b1; wb_we = 1'b0; flush = 1'b0;
    instr = {6'h02, 5'd0, 5'd3, 16'h0010};
    step("lw_r3");
    instr = {6'h00, 5'd3, 5'd0, 5'd4, 11'd0};
    #1;
    checks++;
    if (stall_if !== 1'b1) begin
      failures++;
      $display("FAIL load_use_stall actual=%b expected=1", stall_if);
    end
    step("load_use_bubble");
    checks++;
    if (ex_bus.ex_valid !== 1'b0 || stall_if !== 1'b0) begin
      failures++;
      $display("FAIL load_use_bubble valid=%b stall=%b expected=0/0", ex_bus.ex_valid, stall_if);
    end
    step("load_use_resume");
    checks++;
    if (ex_bus.ex_valid !== 1'b1 || ex_bus.ex_rs !== 5'd3) begin
      failures++;
      $display("FAIL load_use_resume valid=%b rs=%0d expected=1/3", ex_bus.ex_valid, ex_bus.ex_rs);
    end
    instr = {6'h02, 5'd0, 5'd0, 16'h0010};
    step("lw_r0");
    instr = {6'h00, 5'd0, 5'd0, 5'd4, 11'd0};
    step("no_stall_r0");
    instr = {6'h03, 5'd0, 5'd3, 16'h0010};
    step("sw_r3");
    instr = {6'h00, 5'd3, 5'd3, 5'd4, 11'd0};
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      failures++;
      $display("FAIL sw_no_stall actual=%b expected=0", stall_if);
    end
    step("after_sw");
  endtask

  task automatic test_flush();
    instr = {6'h02, 5'd0, 5'd3, 16'h0010};
    step("lw_r3_flush");
    instr = {6'h00, 5'd3, 5'd0, 5'd4, 11'd0};
    flush = 1'b1;
    #1;
    checks++;
    if (stall_if !== 1'b0) begin
      failures++;
      $display("FAIL flush_stall actual=%b expected=0", stall_if);
    end
    step("flush_bubble");
    checks++;
    if ({ex_bus.ex_valid, ex_bus.ex_reg_write, ex_bus.ex_mem_write} !== 3'b000) begin
      failures++;
      $display("FAIL flush_bubble actual=%b expected=000",
               {ex_bus.ex_valid, ex_bus.ex_reg_write, ex_bus.ex_mem_write});
    end
    flush = 1'b0;
  endtask

  task automatic test_illegal();
    instr = 32'hFC22_1234; if_valid = 1'b1;
    step("illegal");
    checks++;
    if ({ex_bus.ex_valid, ex_bus.ex_illegal, ex_bus.ex_reg_write, ex_bus.ex_mem_write} !== 4'b1100) begin
      failures++;
      $display("FAIL illegal actual=%b expected=1100",
               {ex_bus.ex_valid, ex_bus.ex_illegal, ex_bus.ex_reg_write, ex_bus.ex_mem_write});
    end
    instr = 32'h0822_0005; if_valid = 1'b0;
    step("invalid_lw");
    checks++;
    if ({ex_bus.ex_valid, ex_bus.ex_reg_write, ex_bus.ex_mem_read, ex_bus.ex_mem_write,
         ex_bus.ex_branch, ex_bus.ex_jump, ex_bus.ex_illegal} !== 7'b0) begin
      failures++;
      $display("FAIL invalid_lw actual=%b expected=0000000",
               {ex_bus.ex_valid, ex_bus.ex_reg_write, ex_bus.ex_mem_read, ex_bus.ex_mem_write,
                ex_bus.ex_branch, ex_bus.ex_jump, ex_bus.ex_illegal});
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    ops[0] = 6'h00; ops[1] = 6'h01; ops[2] = 6'h02; ops[3] = 6'h03;
    ops[4] = 6'h04; ops[5] = 6'h05; ops[6] = 6'h3F; ops[7] = 6'h2A;
    for (int n = 0; n < 600; n++) begin
      rst     = ($urandom_range(0, 39) != 0);
      flush   = ($urandom_range(0, 7) == 0);
      wb_we   = ($urandom_range(0, 1) == 1);
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = $urandom;
      if (!last_stall) begin
        instr = {ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom), 7'($urandom), 4'($urandom)};
        npc = 8'($urandom);
        if_valid = ($urandom_range(0, 5) != 0);
      end
      step("random");
    end
    rst = 1'b1; flush = 1'b0; wb_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_addi();
    test_bypass();
    test_load_use();
    test_flush();
    test_illegal();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
Name: instr_decode

Overview:
- KGP_RISC decode stage, directly downstream of the instruction fetch stage.
- Consumes the 32-bit instruction and 8-bit next-PC from the IF/ID register.
- Reads a 32x32 register file, decodes control and detects load-use hazards.
- Drives the ID/EX pipeline register and owns the register file write port used by write-back.

Parameters:
DATA_W, 32, register/operand width
PC_W, 8, PC/NPC width (matches the 8-bit instruction memory address)
NREG, 32, register count; address width is log2(NREG) = 5

Ports:
clk1  in  1  single pipeline clock, rising edge
rst  in  1  synchronous, active-low reset
instr  in  32  instruction from IF/ID
npc  in  PC_W  next-PC from IF/ID
if_valid  in  1  IF/ID holds a real instruction
flush  in  1  taken branch/jump resolved in EX; kill the instruction in ID
wb_we  in  1  register write enable from write-back
wb_addr  in  5  write-back destination
wb_data  in  DATA_W  write-back data
stall_if  out  1  combinational; PC and IF/ID must hold this cycle
ex_valid  out  1  ID/EX holds a real instruction
ex_npc  out  PC_W  registered npc
ex_rs_data, ex_rt_data  out  DATA_W  registered operands
ex_imm  out  DATA_W  sign-extended instr[15:0]
ex_rs, ex_rt, ex_rd  out  5  source and destination register numbers
ex_alu_op  out  4  ALU function
ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump  out  1  control bits
ex_illegal  out  1  undefined opcode seen

Behaviour:
- Reset (rst=0 at a clk1 edge): all 32 registers cleared; every ex_* output cleared to 0; stall_if follows its equation.
- Instruction fields:
  - opcode = instr[31:26], rs = [25:21], rt = [20:16], rd_r = [15:11], funct = [3:0], imm = [15:0].
- Decode table:
  - RTYPE (0x00): alu_op = funct, reg_write = 1, dest = rd_r.
  - ADDI (0x01): alu_op = ADD, reg_write = 1, dest = rt.
  - LW (0x02): alu_op = ADD, reg_write = 1, mem_read = 1, dest = rt.
  - SW (0x03): alu_op = ADD, mem_write = 1.
  - BEQ (0x04): alu_op = SUB, branch = 1.
  - J (0x05): jump = 1.
  - Any other opcode: illegal = 1, all write and memory enables 0.
- Source usage:
  - rs used by RTYPE, ADDI, LW, SW, BEQ.
  - rt used by RTYPE, SW, BEQ.
- Register file:
  - r0 reads 0 always; writes to r0 are ignored.
  - Writes occur at the clk1 edge when wb_we = 1.
  - Same-cycle read of wb_addr returns wb_data (write-through bypass), so ID sees the value being written back.
- Load-use hazard:
  - hz = ex_valid & ex_mem_read & ex_rd != 0 & ((rs_used & rs == ex_rd) | (rt_used & rt == ex_rd)) & if_valid.
  - stall_if = hz & ~flush.
- ID/EX update at each clk1 edge, in priority order:
  1. rst = 0 -> clear.
  2. flush = 1 -> bubble (ex_valid = 0, all control bits 0, data don't-care but driven 0).
  3. hz = 1 -> bubble.
  4. Otherwise load: ex_valid = if_valid; control bits gated by if_valid; data fields loaded from decode.
- Latency: one cycle from IF/ID to ID/EX; a stall costs exactly one bubble.
- Simultaneous events:
  - flush + hz: flush wins and stall_if = 0.
  - wb write + same-register read: bypass value is used.
  - Reset mid-stall: clears ID/EX, so the hazard disappears next cycle.
- ex_imm = {{16{imm[15]}}, imm}.
- Operand data is latched even for bubbles' neighbours; consumers must qualify every ex_* output with ex_valid.

Decomposition:
- Shared package kgp_pkg holds:
  - opcode constants OP_RTYPE..OP_J;
  - ALU op constants ALU_ADD = 4'h0, ALU_SUB = 4'h1;
  - DATA_W, PC_W, REG_AW = 5;
  - a ctrl_t struct {reg_write, mem_read, mem_write, branch, jump, illegal, alu_op}.
- One sub-module: reg_file_32x32 (two async read ports with write-through bypass, one sync write port, sync active-low clear).
- Decode logic and hazard detection stay in instr_decode.

Test Plan:
- Reset: hold rst = 0 for 2 cycles with instr = 0x0822_0005 -> all ex_* = 0, ex_valid = 0; a subsequent read of r1..r31 returns 0.
- ADDI r1,r0,-3: instr = 0x0401_FFFD, npc = 0x04, if_valid = 1 -> next cycle ex_valid = 1, ex_imm = 0xFFFF_FFFD, ex_rd = 1, ex_reg_write = 1, ex_alu_op = ADD, ex_npc = 0x04.
- WB bypass: wb_we = 1, wb_addr = 2, wb_data = 0xDEAD_BEEF while ID holds RTYPE rs = 2 -> ex_rs_data = 0xDEAD_BEEF next cycle. Separately, wb to r0 then read r0 -> 0.
- Load-use: LW r3 in ID/EX, then RTYPE rs = 3 in IF/ID:
  - stall_if = 1 for exactly one cycle and ID/EX becomes a bubble (ex_valid = 0);
  - next cycle the RTYPE loads with ex_valid = 1.
  - Repeat with rs = 0 or with SW-in-EX -> no stall.
- Flush priority: flush = 1 together with a load-use hazard -> stall_if = 0, ID/EX bubble, no register write enables asserted.
- Illegal/invalid: opcode 0x3F -> ex_illegal = 1, ex_reg_write = ex_mem_write = 0. if_valid = 0 with a valid-looking LW -> ex_valid = 0, all controls 0.
